// File: rtl/fp_pkg.sv
// Shared definitions for the float-code datapath (encoder and decoder sides).
// Holds the code field widths, the packed code layout and the decoder state encoding.
package fp_pkg;

    localparam int EXP_W  = 3;
    localparam int MANT_W = 5;
    localparam int OUT_W  = 13;

    typedef struct packed {
        logic              S;
        logic [EXP_W-1:0]  E;
        logic [MANT_W-1:0] F;
    } fp_code_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/fp_to_linear_if.sv
// Code-in / linear-out handshake bundle for fp_to_linear.
// The master drives codes and consumes results; the slave is the decoder.
interface fp_to_linear_if #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int OUT_W  = fp_pkg::OUT_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic              S;
    logic [EXP_W-1:0]  E;
    logic [MANT_W-1:0] F;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  D;
    logic              busy;

    modport master (
        output in_valid, S, E, F, out_ready,
        input  in_ready, out_valid, D, busy
    );

    modport slave (
        input  in_valid, S, E, F, out_ready,
        output in_ready, out_valid, D, busy
    );

endinterface

// File: rtl/fp_to_linear_chk.sv
// Protocol and parameter checks for fp_to_linear; simulation-only observer.
// Confirms the output width fits the largest decoded magnitude plus sign.
module fp_to_linear_chk #(
    parameter int EXP_W  = 3,
    parameter int MANT_W = 5,
    parameter int OUT_W  = 13
) (
    input logic             clk,
    input logic             rst_n,
    input logic             in_ready,
    input logic             busy,
    input logic             out_valid,
    input logic             out_ready,
    input logic [OUT_W-1:0] D
);

    generate
        if (OUT_W < MANT_W + (1 << EXP_W)) begin : g_width_err
            $error("fp_to_linear: OUT_W too narrow for MANT_W and EXP_W");
        end
    endgenerate

    a_ready_not_busy : assert property (
        @(posedge clk) disable iff (!rst_n) (in_ready == !busy)
    );

    // A result that is not consumed must stay put, value and valid alike.
    a_hold_stable : assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(D))
    );

endmodule

// File: rtl/fp_to_linear.sv
// Iterative float-code to linear decoder: D = (-1)^S * F * 2^E.
// One left shift per clock while the exponent counts down, then a sign-apply step.
module fp_to_linear #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int OUT_W  = fp_pkg::OUT_W
) (
    input logic           clk,
    input logic           rst_n,
    fp_to_linear_if.slave bus
);

    import fp_pkg::*;

    localparam logic [EXP_W-1:0] CNT_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] OUT_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic               sign_r;
    logic [EXP_W-1:0]   cnt_r;
    logic [OUT_W-2:0]   mag_r;
    logic [OUT_W-1:0]   d_r;
    logic               out_valid_r;

    logic [OUT_W-1:0]   mag_ext_s;
    logic [OUT_W-1:0]   result_s;

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.D         = d_r;

    // Sign-apply: magnitude never reaches the top bit, so negation cannot wrap.
    always_comb begin
        mag_ext_s = {1'b0, mag_r};
        if (sign_r) begin
            result_s = (~mag_ext_s) + OUT_ONE;
        end else begin
            result_s = mag_ext_s;
        end
    end

    // Control FSM with the shift datapath and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sign_r      <= 1'b0;
            cnt_r       <= {EXP_W{1'b0}};
            mag_r       <= {(OUT_W-1){1'b0}};
            d_r         <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_r  <= bus.S;
                        cnt_r   <= bus.E;
                        mag_r   <= {{(OUT_W-1-MANT_W){1'b0}}, bus.F};
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (cnt_r != {EXP_W{1'b0}}) begin
                        mag_r <= {mag_r[OUT_W-3:0], 1'b0};
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        d_r         <= result_s;
                        out_valid_r <= 1'b1;
                        state_r     <= HOLD;
                    end
                end
                HOLD: begin
                    // D is left untouched on release so consumers can still read it.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    fp_to_linear_chk #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W),
        .OUT_W  (OUT_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (bus.in_ready),
        .busy      (bus.busy),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .D         (bus.D)
    );

endmodule
